// File: rtl/wb_everloop_rx.sv
// wb_everloop_rx: decodes the everloop led_fb line into a Wishbone-readable capture RAM with frame status.
// Optional macro EVERLOOP_RX_IRQ_EN adds irq_o = registered (frame_valid | ovf).
module wb_everloop_rx #(
  parameter int SYS_FREQ_HZ    = 150000000,
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 12,
  parameter int N_LEDS         = 35,
  parameter int MEM_ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  led_fb,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_we_i,
  input  logic [1:0]            wb_sel_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_ack_o
`ifdef EVERLOOP_RX_IRQ_EN
  ,
  output logic                  irq_o
`endif
);
  localparam int M = MEM_ADDR_WIDTH;
  localparam int IW = M + 2;
  localparam int UC = SYS_FREQ_HZ / 10000000;
  localparam logic [15:0] U = 16'(UC);
  localparam logic [15:0] U6 = 16'(6 * UC);
  localparam logic [15:0] LATCH = 16'(500 * UC - 1);
  localparam logic [IW-1:0] CAP = IW'(2 ** (M + 1));
  localparam logic [15:0] FRAME_LEN = 16'(4 * N_LEDS);
  typedef enum logic [1:0] {IDLE, HIGH, LOW, FEND} state_t;
  state_t state;
  logic s1, s2, s3;
  logic [15:0] cnt, byte_count, frame_count;
  logic [6:0] sh;
  logic [2:0] nbits;
  logic [IW-1:0] idx, waddr;
  logic [7:0] wdata;
  logic we, busy, frame_valid, ovf, err_glitch, err_partial, len_err;
  logic [7:0] mem_lo [2**M];
  logic [7:0] mem_hi [2**M];
  logic rise, fall, req, clr;
  logic [7:0] nb;
  logic [15:0] reg_rd, ram_rd;
  logic unused_bits;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  assign nb = {sh, cnt > U6};
  assign req = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign clr = req & wb_we_i & (wb_sel_i == 2'b11) & wb_adr_i[M] & (wb_adr_i[1:0] == 2'd0);
  assign unused_bits = ^{wb_dat_i, wb_adr_i[ADDR_WIDTH-1:M+1]};
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      {s3, s2, s1} <= '0;
      cnt <= '0;
    end else begin
      {s3, s2, s1} <= {s2, s1, led_fb};
      cnt <= (rise | fall) ? 16'd0 : (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      sh <= '0;
      nbits <= '0;
      idx <= '0;
      waddr <= '0;
      wdata <= '0;
      we <= 1'b0;
      busy <= 1'b0;
      frame_valid <= 1'b0;
      ovf <= 1'b0;
      err_glitch <= 1'b0;
      err_partial <= 1'b0;
      len_err <= 1'b0;
      byte_count <= '0;
      frame_count <= '0;
    end else begin
      we <= 1'b0;
      if (clr) begin
        frame_valid <= 1'b0;
        ovf <= 1'b0;
        err_glitch <= 1'b0;
        err_partial <= 1'b0;
        len_err <= 1'b0;
      end
      // Frame-end sets below come after the clear, so a new frame's flags win.
      case (state)
        IDLE: if (rise) begin
          state <= HIGH;
          busy <= 1'b1;
        end
        HIGH: if (fall) begin
          state <= LOW;
          if (cnt < U) err_glitch <= 1'b1;
          else if (nbits == 3'd7) begin
            nbits <= '0;
            if (idx == CAP) ovf <= 1'b1;
            else begin
              we <= 1'b1;
              wdata <= nb;
              waddr <= idx;
              idx <= idx + 1'b1;
            end
          end else begin
            sh <= nb[6:0];
            nbits <= nbits + 3'd1;
          end
        end
        LOW: if (rise) state <= HIGH;
             else if (cnt >= LATCH) state <= FEND;
        FEND: begin
          if (nbits != 3'd0) err_partial <= 1'b1;
          if (16'(idx) != FRAME_LEN) len_err <= 1'b1;
          nbits <= '0;
          byte_count <= 16'(idx);
          frame_valid <= 1'b1;
          frame_count <= frame_count + 16'd1;
          busy <= 1'b0;
          idx <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clk)
    if (we) begin
      if (waddr[0]) mem_hi[waddr[M:1]] <= wdata;
      else mem_lo[waddr[M:1]] <= wdata;
    end
  always_comb begin
    ram_rd = {mem_hi[wb_adr_i[M-1:0]], mem_lo[wb_adr_i[M-1:0]]};
    reg_rd = (wb_adr_i[1:0] == 2'd0) ? {10'd0, len_err, err_partial, err_glitch, ovf, busy, frame_valid} :
             (wb_adr_i[1:0] == 2'd1) ? byte_count :
             (wb_adr_i[1:0] == 2'd2) ? frame_count : 16'd0;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req;
      if (req) wb_dat_o <= DATA_WIDTH'(wb_adr_i[M] ? reg_rd : ram_rd);
    end
`ifdef EVERLOOP_RX_IRQ_EN
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) irq_o <= 1'b0;
    else irq_o <= frame_valid | ovf;
`endif
endmodule

// File: tb/tb_wb_everloop_rx.sv
// tb_wb_everloop_rx: directed checks of wb_everloop_rx with a scaled clock (U=2) and small RAM (16 bytes, frame 8 bytes).
module tb_wb_everloop_rx;
  localparam int MAW = 3;
  localparam logic [11:0] ST = 12'd8, BC = 12'd9, FC = 12'd10, R3 = 12'd11;
  logic clk = 1'b0, resetn = 1'b0, led_fb = 1'b0;
  logic wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0;
  logic [1:0] wb_sel_i = 2'b11;
  logic [11:0] wb_adr_i = '0;
  logic [15:0] wb_dat_i = '0, wb_dat_o;
  logic wb_ack_o;
  int checks = 0, errors = 0;
  logic [15:0] rd;
`ifdef EVERLOOP_RX_IRQ_EN
  logic irq_o;
`endif
  wb_everloop_rx #(.SYS_FREQ_HZ(20000000), .DATA_WIDTH(16), .ADDR_WIDTH(12), .N_LEDS(2), .MEM_ADDR_WIDTH(MAW)) dut (
    .clk(clk), .resetn(resetn), .led_fb(led_fb), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o)
`ifdef EVERLOOP_RX_IRQ_EN
    , .irq_o(irq_o)
`endif
  );
  always #5 clk = ~clk;

  task automatic hold(input logic v, input int n);
    led_fb = v;
    repeat (n) @(negedge clk);
  endtask
  task automatic send_bit(input logic b);
    hold(1'b1, b ? 20 : 6);
    hold(1'b0, 8);
  endtask
  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask
  task automatic latch();
    hold(1'b0, 1100);
  endtask
  task automatic wb_cycle(input logic [11:0] a, input logic w, input logic [1:0] s, input logic [15:0] d, output logic [15:0] q);
    bit got = 0;
    @(negedge clk);
    wb_adr_i = a; wb_we_i = w; wb_sel_i = s; wb_dat_i = d; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    q = 'x;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      if (wb_ack_o) begin got = 1; q = wb_dat_o; end
    end
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL ack_timeout adr=%0h", a); end
    @(posedge clk); #1;
    checks++;
    if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL ack_one_cycle got=%b want=0", wb_ack_o); end
  endtask
  task automatic rd_(input logic [11:0] a, output logic [15:0] q);
    wb_cycle(a, 1'b0, 2'b11, 16'h0, q);
  endtask
  task automatic wr_(input logic [11:0] a, input logic [1:0] s, input logic [15:0] d);
    logic [15:0] q;
    wb_cycle(a, 1'b1, s, d, q);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (wb_ack_o !== 1'b0 || wb_dat_o !== 16'h0) begin errors++; $display("FAIL reset_outputs ack=%b dat=%h want 0/0000", wb_ack_o, wb_dat_o); end
    resetn = 1'b1;
    rd_(ST, rd); checks++; if (rd !== 16'h0) begin errors++; $display("FAIL reset_status got=%h want=0000", rd); end
    rd_(BC, rd); checks++; if (rd !== 16'h0) begin errors++; $display("FAIL reset_bytecount got=%h want=0000", rd); end
    rd_(FC, rd); checks++; if (rd !== 16'h0) begin errors++; $display("FAIL reset_framecount got=%h want=0000", rd); end
  endtask

  task automatic test_single();
    send_byte(8'hA5); latch();
    rd_(12'd0, rd); checks++; if (rd[7:0] !== 8'hA5) begin errors++; $display("FAIL single_ram got=%h want=A5", rd[7:0]); end
    rd_(BC, rd); checks++; if (rd !== 16'd1) begin errors++; $display("FAIL single_bytecount got=%h want=0001", rd); end
    rd_(ST, rd); checks++; if (rd !== 16'h21) begin errors++; $display("FAIL single_status got=%h want=0021", rd); end
    rd_(FC, rd); checks++; if (rd !== 16'd1) begin errors++; $display("FAIL single_framecount got=%h want=0001", rd); end
  endtask

  task automatic test_full_frame();
    wr_(ST, 2'b11, 16'hFFFF);
    for (int k = 0; k < 8; k++) send_byte(k[0] ? 8'h34 : 8'h12);
    latch();
`ifdef EVERLOOP_RX_IRQ_EN
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_set got=%b want=1", irq_o); end
`endif
    for (int w = 0; w < 4; w++) begin
      rd_(12'(w), rd); checks++;
      if (rd !== 16'h3412) begin errors++; $display("FAIL frame_word%0d got=%h want=3412", w, rd); end
    end
    rd_(BC, rd); checks++; if (rd !== 16'd8) begin errors++; $display("FAIL frame_bytecount got=%h want=0008", rd); end
    rd_(ST, rd); checks++; if (rd !== 16'h01) begin errors++; $display("FAIL frame_status got=%h want=0001", rd); end
    wr_(ST, 2'b11, 16'h0);
`ifdef EVERLOOP_RX_IRQ_EN
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_clear got=%b want=0", irq_o); end
`endif
  endtask

  task automatic test_glitch();
    send_bit(1'b1);
    hold(1'b0, 3); hold(1'b1, 1); hold(1'b0, 4);
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    latch();
    rd_(12'd0, rd); checks++; if (rd !== 16'h3480) begin errors++; $display("FAIL glitch_ram got=%h want=3480", rd); end
    rd_(ST, rd); checks++; if (rd !== 16'h29) begin errors++; $display("FAIL glitch_status got=%h want=0029", rd); end
    wr_(ST, 2'b11, 16'h0);
  endtask

  task automatic test_partial();
    for (int i = 0; i < 5; i++) send_bit(i[0] ? 1'b0 : 1'b1);
    latch();
    rd_(ST, rd); checks++; if (rd !== 16'h31) begin errors++; $display("FAIL partial_status got=%h want=0031", rd); end
    rd_(BC, rd); checks++; if (rd !== 16'd0) begin errors++; $display("FAIL partial_bytecount got=%h want=0000", rd); end
    wr_(ST, 2'b11, 16'h1234);
    rd_(ST, rd); checks++; if (rd !== 16'h00) begin errors++; $display("FAIL partial_clear got=%h want=0000", rd); end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 20; k++) send_byte(8'(k));
    rd_(ST, rd); checks++; if (rd !== 16'h06) begin errors++; $display("FAIL ovf_busy_status got=%h want=0006", rd); end
    latch();
    rd_(ST, rd); checks++; if (rd !== 16'h25) begin errors++; $display("FAIL ovf_status got=%h want=0025", rd); end
    rd_(BC, rd); checks++; if (rd !== 16'd16) begin errors++; $display("FAIL ovf_bytecount got=%h want=0010", rd); end
    rd_(12'd7, rd); checks++; if (rd !== 16'h0F0E) begin errors++; $display("FAIL ovf_word7 got=%h want=0F0E", rd); end
    rd_(FC, rd); checks++; if (rd !== 16'd5) begin errors++; $display("FAIL ovf_framecount got=%h want=0005", rd); end
  endtask

  task automatic test_wb_access();
    wr_(12'd0, 2'b11, 16'hFFFF);
    rd_(12'd0, rd); checks++; if (rd !== 16'h0100) begin errors++; $display("FAIL ram_write_ignored got=%h want=0100", rd); end
    wr_(ST, 2'b01, 16'hFFFF);
    rd_(ST, rd); checks++; if (rd !== 16'h25) begin errors++; $display("FAIL partial_sel_ignored got=%h want=0025", rd); end
    rd_(R3, rd); checks++; if (rd !== 16'h0) begin errors++; $display("FAIL reg3_zero got=%h want=0000", rd); end
  endtask

  task automatic test_reset_midframe();
    send_bit(1'b1); send_bit(1'b0); hold(1'b1, 10);
    resetn = 1'b0; led_fb = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    rd_(ST, rd); checks++; if (rd !== 16'h0) begin errors++; $display("FAIL midreset_status got=%h want=0000", rd); end
    rd_(FC, rd); checks++; if (rd !== 16'h0) begin errors++; $display("FAIL midreset_framecount got=%h want=0000", rd); end
    send_byte(8'h5A); latch();
    rd_(BC, rd); checks++; if (rd !== 16'd1) begin errors++; $display("FAIL midreset_bytecount got=%h want=0001", rd); end
    rd_(12'd0, rd); checks++; if (rd[7:0] !== 8'h5A) begin errors++; $display("FAIL midreset_ram got=%h want=5A", rd[7:0]); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_frame();
    test_glitch();
    test_partial();
    test_overflow();
    test_wb_access();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
